// File: rtl/seq_shift_right.sv
// ---------------------------------------------------------------------------
// seq_shift_right
//   Multi-cycle right shifter that recovers word offsets from 18-bit byte
//   offsets. It shifts one bit per clock. A sticky flag records whether any
//   nonzero bit was shifted out, which means the offset was not word-aligned.
//   The block is driven by a start/done handshake from the multi-cycle
//   datapath.
//
//   Optional feature macro: ARITH_SHIFT_EN
//     When defined, the arith port is present. It is latched with start;
//     arith=1 selects sign-fill using the latched A[WIDTH-1].
//     When undefined, the shift is always logical (fill 0).
//
// Ports
//   clk     in   1        rising-edge clock
//   reset   in   1        synchronous, active-high; overrides everything
//   start   in   1        request; sampled only while busy==0
//   A       in   WIDTH    operand, latched on an accepted start
//   shamt   in   SHAMT_W  shift amount, latched on an accepted start
//   arith   in   1        (ARITH_SHIFT_EN only) 1 = sign-fill shift
//   S       out  WIDTH    result; held from done until the next accepted start
//   sticky  out  1        OR of all bits shifted out; held with S
//   busy    out  1        high throughout SHIFT only
//   done    out  1        one-cycle pulse when S/sticky become valid
//
// State | meaning
//   IDLE  | waiting for start; S/sticky hold the last result
//   SHIFT | shifting one bit per cycle until cnt reaches zero
//   DONE  | result valid (done=1); start here is accepted back-to-back
// ---------------------------------------------------------------------------
module seq_shift_right #(
    parameter int WIDTH   = 18,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [SHAMT_W-1:0] shamt,
`ifdef ARITH_SHIFT_EN
    input  logic               arith,
`endif
    output logic [WIDTH-1:0]   S,
    output logic               sticky,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   s_q, s_n;
    logic               sticky_q, sticky_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               fill_q, fill_n;
    logic [CNT_W-1:0]   cnt_load;
    logic               fill_load;

    // Amounts of WIDTH or more would shift everything out, so they saturate
    // at WIDTH. This keeps the worst-case latency at WIDTH+1.
    always_comb begin
        if (int'(shamt) >= WIDTH)
            cnt_load = CNT_W'(WIDTH);
        else
            cnt_load = CNT_W'(shamt);
    end

`ifdef ARITH_SHIFT_EN
    assign fill_load = arith & A[WIDTH-1];
`else
    assign fill_load = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            s_q      <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            fill_q   <= 1'b0;
        end else begin
            state    <= state_n;
            s_q      <= s_n;
            sticky_q <= sticky_n;
            cnt_q    <= cnt_n;
            fill_q   <= fill_n;
        end
    end

    always_comb begin
        state_n  = state;
        s_n      = s_q;
        sticky_n = sticky_q;
        cnt_n    = cnt_q;
        fill_n   = fill_q;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    s_n      = A;
                    sticky_n = 1'b0;
                    cnt_n    = cnt_load;
                    fill_n   = fill_load;
                    state_n  = (cnt_load == '0) ? DONE : SHIFT;
                end else begin
                    state_n  = IDLE;
                end
            end
            SHIFT: begin
                s_n      = {fill_q, s_q[WIDTH-1:1]};
                sticky_n = sticky_q | s_q[0];
                cnt_n    = cnt_q - CNT_W'(1);
                // cnt is never zero in SHIFT; the last shift happens at cnt==1.
                if (cnt_q == CNT_W'(1))
                    state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign S      = s_q;
    assign sticky = sticky_q;
    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);

endmodule
